// File: rtl/alu_sched_if.sv
// -----------------------------------------------------------------------------
// alu_sched_if
// Bundles the requester, response and ALU-side signals of the alu_sched
// round-robin ALU scheduler.
//
//   slave  modport : the scheduler view
//                    (requests/ALU result in; grants/response/ALU operands out)
//   master modport : the environment view (requesters, response consumer, ALU)
//
// Signals
//   req_valid [NUM_REQ]   per-requester request valid
//   req_ready [NUM_REQ]   per-requester accept, at most one bit high
//   req_a/req_b [8*N]     operands, requester i at [8i+7:8i]
//   req_op    [2*N]       00 add, 01 sub, 10 mul, 11 div; requester i at [2i+1:2i]
//   rsp_valid/rsp_ready   response handshake
//   rsp_data  [8]         result
//   rsp_id    [ID_W]      requester that owns the result
//   rsp_err               divide-by-zero flag
//   alu_a/alu_b [8]       registered ALU operands
//   alu_sel   [4]         registered ALU select (4'b0100 = hold)
//   alu_out   [8]         ALU result, one cycle after operands/select
// -----------------------------------------------------------------------------
interface alu_sched_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_ready;
   logic [8*NUM_REQ-1:0] req_a;
   logic [8*NUM_REQ-1:0] req_b;
   logic [2*NUM_REQ-1:0] req_op;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [7:0]           rsp_data;
   logic [ID_W-1:0]      rsp_id;
   logic                 rsp_err;
   logic [7:0]           alu_a;
   logic [7:0]           alu_b;
   logic [3:0]           alu_sel;
   logic [7:0]           alu_out;

   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready, alu_out,
      output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err,
             alu_a, alu_b, alu_sel
   );

   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready, alu_out,
      input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err,
             alu_a, alu_b, alu_sel
   );
endinterface

// File: rtl/alu_sched.sv
// -----------------------------------------------------------------------------
// alu_sched
// Round-robin scheduler sharing one registered 8-bit ALU between NUM_REQ
// requesters. One operation is in flight at a time:
//   IDLE -> (accept) -> ISSUE -> CAPTURE -> RESP -> IDLE
// Divide by zero is caught at accept and answered directly (IDLE -> RESP)
// with rsp_data=8'hFF, rsp_err=1, without touching the ALU.
//
// Ports
//   clock          clock
//   reset          asynchronous, active-high reset
//   bus            alu_sched_if.slave (request, response and ALU signals)
//   op_count [16]  saturating count of response handshakes
//                  (present only when ALU_SCHED_STATS_EN is defined)
//
// Optional feature macro: ALU_SCHED_STATS_EN
// -----------------------------------------------------------------------------
module alu_sched #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic              clock,
   input  logic              reset,
   alu_sched_if.slave        bus
`ifdef ALU_SCHED_STATS_EN
   ,
   output logic [15:0]       op_count
`endif
);

   localparam logic [3:0] SEL_HOLD = 4'b0100;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

   state_t          state_q;
   logic [ID_W-1:0] rr_ptr_q;
   logic            rsp_valid_q;
   logic [7:0]      rsp_data_q;
   logic [ID_W-1:0] rsp_id_q;
   logic            rsp_err_q;
   logic [7:0]      alu_a_q;
   logic [7:0]      alu_b_q;
   logic [3:0]      alu_sel_q;

   logic            gnt_vld;
   logic [ID_W-1:0] gnt_idx;
   logic [ID_W:0]   cand;
   logic [7:0]      gnt_a;
   logic [7:0]      gnt_b;
   logic [1:0]      gnt_op;
   logic            gnt_div0;
   logic [NUM_REQ-1:0] req_ready_c;

   // Round-robin search starting at rr_ptr. Scanning from the farthest
   // offset down lets the nearest valid requester overwrite the result.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(NUM_REQ))
            cand = cand - (ID_W+1)'(NUM_REQ);
         if (bus.req_valid[cand[ID_W-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand[ID_W-1:0];
         end
      end
   end

   // Operand mux for the granted requester.
   always_comb begin
      gnt_a  = '0;
      gnt_b  = '0;
      gnt_op = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_idx == ID_W'(i)) begin
            gnt_a  = bus.req_a[8*i +: 8];
            gnt_b  = bus.req_b[8*i +: 8];
            gnt_op = bus.req_op[2*i +: 2];
         end
      end
   end

   assign gnt_div0 = (gnt_op == 2'b11) && (gnt_b == 8'd0);

   always_comb begin
      req_ready_c = '0;
      if (state_q == S_IDLE && gnt_vld)
         req_ready_c[gnt_idx] = 1'b1;
   end

   // In IDLE a grant is always handshaken on the next edge, because the
   // granted requester's ready is driven from its own valid.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
         rsp_err_q   <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_sel_q   <= SEL_HOLD;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (gnt_vld) begin
                  rsp_id_q <= gnt_idx;
                  rr_ptr_q <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
                  if (gnt_div0) begin
                     rsp_data_q  <= 8'hFF;
                     rsp_err_q   <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     state_q     <= S_RESP;
                  end else begin
                     alu_a_q   <= gnt_a;
                     alu_b_q   <= gnt_b;
                     alu_sel_q <= {2'b00, gnt_op};
                     rsp_err_q <= 1'b0;
                     state_q   <= S_ISSUE;
                  end
               end
            end
            // ALU registers operands at this edge; park it on hold afterwards.
            S_ISSUE: begin
               alu_sel_q <= SEL_HOLD;
               state_q   <= S_CAPTURE;
            end
            S_CAPTURE: begin
               rsp_data_q  <= bus.alu_out;
               rsp_valid_q <= 1'b1;
               state_q     <= S_RESP;
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready = req_ready_c;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.alu_sel   = alu_sel_q;

`ifdef ALU_SCHED_STATS_EN
   logic [15:0] op_count_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         op_count_q <= '0;
      else if (rsp_valid_q && bus.rsp_ready && op_count_q != 16'hFFFF)
         op_count_q <= op_count_q + 16'd1;
   end

   assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// -----------------------------------------------------------------------------
// tb_alu_sched
// Self-checking bench for alu_sched with NUM_REQ=4. Hosts a behavioural ALU
// on the alu_* side and compares the scheduler against a reference model of
// round-robin grant order, result arithmetic, latency and handshake rules.
// -----------------------------------------------------------------------------
module tb_alu_sched;

   logic clock = 1'b0;
   logic reset;
`ifdef ALU_SCHED_STATS_EN
   logic [15:0] op_count;
`endif

   alu_sched_if #(.NUM_REQ(4), .ID_W(2)) bus ();

   alu_sched #(.NUM_REQ(4), .ID_W(2)) dut (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus)
`ifdef ALU_SCHED_STATS_EN
      ,
      .op_count (op_count)
`endif
   );

   always #5 clock = ~clock;

   // External ALU: registers its result one edge after operands/select.
   always @(posedge clock) begin
      if (bus.alu_sel[3:2] == 2'b00) begin
         case (bus.alu_sel[1:0])
            2'b00:   bus.alu_out <= bus.alu_a + bus.alu_b;
            2'b01:   bus.alu_out <= bus.alu_a - bus.alu_b;
            2'b10:   bus.alu_out <= bus.alu_a * bus.alu_b;
            default: bus.alu_out <= (bus.alu_b == 8'd0) ? 8'hFF : bus.alu_a / bus.alu_b;
         endcase
      end
   end

   int n_chk = 0;
   int n_err = 0;
   int mdl_ptr = 0;
   int mdl_cnt = 0;
   logic [7:0] ta [4];
   logic [7:0] tb [4];
   logic [1:0] top [4];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, wanted %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference result: {err, data} from plain integer arithmetic.
   function automatic logic [8:0] ref_result(logic [7:0] a, logic [7:0] b, logic [1:0] op);
      int r;
      case (op)
         2'd0: r = int'(a) + int'(b);
         2'd1: r = int'(a) - int'(b);
         2'd2: r = int'(a) * int'(b);
         default: begin
            if (b == 8'd0) return {1'b1, 8'hFF};
            r = int'(a) / int'(b);
         end
      endcase
      return {1'b0, 8'(r)};
   endfunction

   task automatic load_operands();
      for (int i = 0; i < 4; i++) begin
         bus.req_a[8*i +: 8]  = ta[i];
         bus.req_b[8*i +: 8]  = tb[i];
         bus.req_op[2*i +: 2] = top[i];
      end
   endtask

   // Called at a negedge with the DUT in IDLE. Runs one full transaction
   // with 'hold' cycles of response backpressure.
   task automatic run_op(input logic [3:0] mask, input int hold, output int g, output logic [8:0] res);
      int lat;
      g = -1;
      for (int k = 0; k < 4; k++) begin
         int idx;
         idx = (mdl_ptr + k) % 4;
         if (g < 0 && ((mask >> idx) & 4'b0001) == 4'b0001) g = idx;
      end
      res = ref_result(ta[g], tb[g], top[g]);
      load_operands();
      bus.req_valid = mask;
      bus.rsp_ready = (hold == 0);
      #1;
      check("grant", 32'(bus.req_ready), 32'(4'b0001 << g));
      @(posedge clock);
      @(negedge clock);
      check("ready_pulse", 32'(bus.req_ready), 32'd0);
      if (res[8]) check("alu_sel_hold", 32'(bus.alu_sel), 32'h4);
      else begin
         check("alu_sel_issue", 32'(bus.alu_sel), 32'(top[g]));
         check("alu_a", 32'(bus.alu_a), 32'(ta[g]));
         check("alu_b", 32'(bus.alu_b), 32'(tb[g]));
      end
      lat = 1;
      while (!bus.rsp_valid && lat < 8) begin
         @(negedge clock);
         lat++;
      end
      check("latency", 32'(lat), res[8] ? 32'd1 : 32'd3);
      check("rsp_data", 32'(bus.rsp_data), 32'(res[7:0]));
      check("rsp_id", 32'(bus.rsp_id), 32'(g));
      check("rsp_err", 32'(bus.rsp_err), 32'(res[8]));
      for (int h = 0; h < hold; h++) begin
         @(negedge clock);
         check("bp_valid", 32'(bus.rsp_valid), 32'd1);
         check("bp_data", 32'({bus.rsp_err, bus.rsp_data}), 32'(res));
         check("bp_id", 32'(bus.rsp_id), 32'(g));
         check("bp_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clock);
      check("rsp_drop", 32'(bus.rsp_valid), 32'd0);
      mdl_ptr = (g + 1) % 4;
      if (mdl_cnt < 65535) mdl_cnt++;
`ifdef ALU_SCHED_STATS_EN
      check("op_count", 32'(op_count), 32'(mdl_cnt));
`endif
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
      check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      check({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
      check({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'd0);
      check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
      check({tag, "_alu"}, 32'({bus.alu_a, bus.alu_b}), 32'd0);
      check({tag, "_alu_sel"}, 32'(bus.alu_sel), 32'h4);
`ifdef ALU_SCHED_STATS_EN
      check({tag, "_op_count"}, 32'(op_count), 32'd0);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      logic [8:0] res;
      reset = 1'b1;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin ta[i] = '0; tb[i] = '0; top[i] = '0; end
      load_operands();
      repeat (2) @(negedge clock);
      check_reset_outputs("reset");
      reset = 1'b0;
      // No requests: stays idle, nothing granted.
      repeat (3) begin
         @(negedge clock);
         check("idle_ready", 32'(bus.req_ready), 32'd0);
         check("idle_valid", 32'(bus.rsp_valid), 32'd0);
      end

      // Single add, truncating mul and sub, divide by zero.
      ta[0] = 8'd20; tb[0] = 8'd22; top[0] = 2'b00;
      run_op(4'b0001, 0, g, res);
      check("add_result", 32'(res), 32'd42);
      ta[1] = 8'd16; tb[1] = 8'd17; top[1] = 2'b10;
      run_op(4'b0010, 0, g, res);
      check("mul_result", 32'(res), 32'h10);
      ta[2] = 8'd3; tb[2] = 8'd5; top[2] = 2'b01;
      run_op(4'b0100, 0, g, res);
      check("sub_result", 32'(res), 32'hFE);
      ta[3] = 8'd9; tb[3] = 8'd0; top[3] = 2'b11;
      run_op(4'b1000, 0, g, res);
      check("div0_result", 32'(res), 32'h1FF);

      // Round robin with all requesters valid: 0,1,2,3,0.
      for (int i = 0; i < 4; i++) begin
         ta[i] = 8'($urandom); tb[i] = 8'($urandom_range(1, 255)); top[i] = 2'($urandom);
      end
      for (int n = 0; n < 5; n++) begin
         run_op(4'b1111, 0, g, res);
         check("rr_order", 32'(g), 32'(n % 4));
      end

      // Backpressure, then the next requester is granted.
      run_op(4'b1111, 5, g, res);
      check("bp_grant", 32'(g), 32'd1);
      run_op(4'b1111, 0, g, res);
      check("bp_next", 32'(g), 32'd2);

      // Reset during CAPTURE.
      for (int i = 0; i < 4; i++) top[i] = 2'b00;
      load_operands();
      bus.req_valid = 4'b1111;
      bus.rsp_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.req_valid = '0;
      @(negedge clock);
      reset = 1'b1;
      #1;
      check_reset_outputs("midop");
      @(negedge clock);
      reset = 1'b0;
      mdl_ptr = 0;
      mdl_cnt = 0;
      repeat (4) begin
         @(negedge clock);
         check("post_reset_valid", 32'(bus.rsp_valid), 32'd0);
      end
      run_op(4'b0100, 0, g, res);
      check("post_reset_grant", 32'(g), 32'd2);
      run_op(4'b1111, 0, g, res);
      check("rr_ptr_after_reset", 32'(g), 32'd3);

      // Randomized traffic.
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < 4; i++) begin
            ta[i]  = 8'($urandom);
            tb[i]  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            top[i] = 2'($urandom);
         end
         run_op(4'($urandom_range(1, 15)), $urandom_range(0, 2), g, res);
      end
      bus.req_valid = '0;
      @(negedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
